branch_predictor: RTL

//  Parametrised fetch-stage branch predictor (BTB + 2-bit-style saturating counters) for the 5-stage RV32I core.

---
 rtl/bpred_pkg.sv | 41 ++++
 rtl/branch_predictor_sat_counter.sv | 24 ++
 rtl/branch_predictor.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bpred_pkg.sv
// Shared constants, flag struct and PC slicing helpers for the branch predictor.
package bpred_pkg;

    // Counter encodings for the default 2-bit counter.
    localparam int                   CTR_W_DEF = 2;
    localparam logic [CTR_W_DEF-1:0] CTR_WNT   = 2'b01;
    localparam logic [CTR_W_DEF-1:0] CTR_WT    = 2'b10;
    localparam logic [CTR_W_DEF-1:0] CTR_MAX   = 2'b11;

    // Per-entry control bits; kept in reset flops, unlike tag/target.
    typedef struct packed {
        logic valid;
        logic is_jump;
    } entry_flags_t;

    // Weakly-taken value for a counter of width w: MSB set, rest clear.
    function automatic logic [31:0] ctr_wt(input int w);
        return 32'd1 << (w - 1);
    endfunction

    // Weakly-not-taken value: just below weakly-taken.
    function automatic logic [31:0] ctr_wnt(input int w);
        return ctr_wt(w) - 32'd1;
    endfunction

    // Saturation ceiling for a counter of width w.
    function automatic logic [31:0] ctr_max(input int w);
        return (ctr_wt(w) << 1) - 32'd1;
    endfunction

    // Table index: word-address bits directly above the byte offset.
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Tag: every PC bit above the index field.
    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Up/down saturating counter next-value logic (purely combinational).
module sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] i_ctr,
    input  logic         i_inc,
    output logic [W-1:0] o_ctr
);

    localparam logic [W-1:0] LP_MAX = '1;
    localparam logic [W-1:0] LP_MIN = '0;

    // Step toward the outcome, clamping at either end of the range.
    always_comb begin
        // NOTE: default assignment first so no path leaves o_ctr unassigned (no latch).
        o_ctr = i_ctr;
        if (i_inc) begin
            if (i_ctr != LP_MAX) o_ctr = i_ctr + W'(1);
        end else begin
            if (i_ctr != LP_MIN) o_ctr = i_ctr - W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with saturating counters,
// same-cycle lookup, E-stage training, mispredict detection and counting.
module branch_predictor
    import bpred_pkg::*;
#(
    parameter int PC_W    = 13,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             pred_en_i,
    input  logic [PC_W-1:0]  pc_f_i,
    output logic             pred_taken_o,
    output logic [PC_W-1:0]  pred_target_o,
    input  logic             upd_valid_i,
    input  logic             upd_is_jump_i,
    input  logic [PC_W-1:0]  upd_pc_i,
    input  logic             upd_taken_i,
    input  logic [PC_W-1:0]  upd_target_i,
    input  logic             upd_pred_taken_i,
    input  logic [PC_W-1:0]  upd_pred_tgt_i,
    input  logic             flush_tbl_i,
    output logic             mispredict_o,
    output logic [PC_W-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - 2 - IDX_W;

    localparam logic [CTR_W-1:0] LP_CTR_WNT = CTR_W'(ctr_wnt(CTR_W));
    localparam logic [CTR_W-1:0] LP_CTR_WT  = CTR_W'(ctr_wt(CTR_W));
    localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;
    localparam logic [PC_W-1:0]  LP_FOUR    = PC_W'(4);

    // Table storage.
    entry_flags_t     r_flags  [ENTRIES];
    logic [CTR_W-1:0] r_ctr    [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [PC_W-1:0]  r_target [ENTRIES];
    logic [CNT_W-1:0] r_cnt;

    // Lookup side.
    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic             w_f_taken;

    // Update side.
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic             w_u_write;
    logic [CTR_W-1:0] w_ctr_next;
    logic             w_mispredict;

    assign w_f_idx = IDX_W'(pc_index(32'(pc_f_i), IDX_W));
    assign w_f_tag = TAG_W'(pc_tag(32'(pc_f_i), IDX_W));
    assign w_u_idx = IDX_W'(pc_index(32'(upd_pc_i), IDX_W));
    assign w_u_tag = TAG_W'(pc_tag(32'(upd_pc_i), IDX_W));

    // Lookup reads current table contents only; an update in the same cycle
    // becomes visible on the following cycle.
    assign w_f_hit   = r_flags[w_f_idx].valid && (r_tag[w_f_idx] == w_f_tag);
    assign w_f_taken = w_f_hit && (r_flags[w_f_idx].is_jump || r_ctr[w_f_idx][CTR_W-1]);

    assign pred_taken_o  = pred_en_i && w_f_taken;
    assign pred_target_o = pred_taken_o ? r_target[w_f_idx] : pc_f_i + LP_FOUR;

    // Resolution against the prediction that travelled with the instruction.
    assign w_mispredict = upd_valid_i &&
                          ((upd_taken_i != upd_pred_taken_i) ||
                           (upd_taken_i && (upd_target_i != upd_pred_tgt_i)));
    assign mispredict_o  = w_mispredict;
    assign redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + LP_FOUR;
    assign mispred_cnt_o = r_cnt;

    assign w_u_hit   = r_flags[w_u_idx].valid && (r_tag[w_u_idx] == w_u_tag);
    assign w_u_write = upd_valid_i && !flush_tbl_i;

    sat_counter #(
        .W (CTR_W)
    ) u_sat_counter (
        .i_ctr (r_ctr[w_u_idx]),
        .i_inc (upd_taken_i),
        .o_ctr (w_ctr_next)
    );

    // Valid/is_jump/counter state: reset, flush, hit training and allocation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                // NOTE: non-blocking assignments for all sequential state so every
                // flop samples pre-edge values regardless of statement order.
                r_flags[i] <= '0;
                r_ctr[i]   <= LP_CTR_WNT;
            end
        end else if (flush_tbl_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_flags[i].valid <= 1'b0;
            end
        end else if (upd_valid_i) begin
            if (w_u_hit) begin
                if (upd_is_jump_i) begin
                    r_flags[w_u_idx].is_jump <= 1'b1;
                end else begin
                    r_ctr[w_u_idx] <= w_ctr_next;
                end
            end else if (upd_taken_i) begin
                r_flags[w_u_idx] <= '{valid: 1'b1, is_jump: upd_is_jump_i};
                r_ctr[w_u_idx]   <= LP_CTR_WT;
            end
        end
    end

    // Tag/target payload, written alongside the control bits above.
    always_ff @(posedge clk_i) begin
        // NOTE: tag/target are deliberately unreset; entries are qualified by
        // valid, so clearing this array would only cost reset fan-out.
        if (w_u_write) begin
            if (w_u_hit) begin
                if (upd_is_jump_i || upd_taken_i) r_target[w_u_idx] <= upd_target_i;
            end else if (upd_taken_i) begin
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= upd_target_i;
            end
        end
    end

    // Mispredict performance counter, saturating at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_mispredict && (r_cnt != LP_CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule
